// File: rtl/onehot_decoder_seq.sv
// Registered N-to-2^N one-hot select sequencer with a valid/ready request port.
// It has two modes: single (one slot) and scan (every output in turn, starting at sel).
// Each slot lasts hold+1 enabled cycles.
// Optional build macro: DEC_GAP_EN inserts a one-cycle all-zero GAP between scan slots
// (break-before-make).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en                  advance enable; low freezes the sequencer
//   in_valid/in_ready   request handshake (ready only when idle)
//   sel, hold, mode     request fields, sampled on accept
//   y, busy, done       registered one-hot outputs, activity flag, completion pulse
module onehot_decoder_seq #(
  parameter int N      = 2,
  parameter int HOLD_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        sel,
  input  logic [HOLD_W-1:0]   hold,
  input  logic                mode,
  output logic [(1<<N)-1:0]   y,
  output logic                busy,
  output logic                done
);

  localparam int W = 1 << N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef DEC_GAP_EN
    GAP    = 2'd2,
`endif
    ACTIVE = 2'd1
  } state_t;

  state_t              state;
  logic [N-1:0]        idx;
  logic [N-1:0]        visited;
  logic [HOLD_W-1:0]   cnt;
  logic [HOLD_W-1:0]   hold_r;
  logic                mode_r;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      visited <= '0;
      cnt     <= '0;
      hold_r  <= '0;
      mode_r  <= 1'b0;
      y       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // done is a single-cycle pulse; it is only raised on a slot end below.
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Acceptance is deliberately not gated by en.
          if (in_valid) begin
            idx     <= sel;
            cnt     <= hold;
            hold_r  <= hold;
            mode_r  <= mode;
            visited <= '0;
            y       <= onehot(sel);
            busy    <= 1'b1;
            state   <= ACTIVE;
          end else begin
            y    <= '0;
            busy <= 1'b0;
          end
        end

        ACTIVE: begin
          if (en) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (!mode_r || (visited == {N{1'b1}})) begin
              // Last slot of the request.
              y     <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx     <= idx + 1'b1;   // wraps modulo 2^N
              visited <= visited + 1'b1;
              cnt     <= hold_r;
`ifdef DEC_GAP_EN
              y       <= '0;
              state   <= GAP;
`else
              y       <= onehot(idx + 1'b1);
`endif
            end
          end
        end

`ifdef DEC_GAP_EN
        GAP: begin
          // idx already points at the next slot.
          if (en) begin
            y     <= onehot(idx);
            state <= ACTIVE;
          end
        end
`endif

        default: begin
          state <= IDLE;
          y     <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq.
// It drives an N=2 instance and an N=3 instance (HOLD_W=4) with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;

  // N=2 instance
  logic       en, in_valid, mode;
  logic       in_ready;
  logic [1:0] sel;
  logic [3:0] hold;
  logic [3:0] y;
  logic       busy, done;

  // N=3 instance
  logic       en3, in_valid3, mode3;
  logic       in_ready3;
  logic [2:0] sel3;
  logic [3:0] hold3;
  logic [7:0] y3;
  logic       busy3, done3;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.N(2), .HOLD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .hold(hold), .mode(mode), .y(y), .busy(busy), .done(done)
  );

  onehot_decoder_seq #(.N(3), .HOLD_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .hold(hold3), .mode(mode3), .y(y3), .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".y"},        {28'd0, y},   32'h0);
    check({tag, ".busy"},     {31'd0, busy}, 32'h0);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'h1);
  endtask

  int seq[$];

  initial begin
    rst_n = 1'b0;
    en = 1'b1; in_valid = 1'b0; sel = '0; hold = '0; mode = 1'b0;
    en3 = 1'b1; in_valid3 = 1'b0; sel3 = '0; hold3 = '0; mode3 = 1'b0;

    // Reset state
    #2;
    check_idle("rst");
    check("rst.done", {31'd0, done}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");

    // Single mode: sel=2, hold=3 -> 0100 for 4 cycles, then done
    sel = 2'd2; hold = 4'd3; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single.y0", {28'd0, y}, 32'h4);
    check("single.busy", {31'd0, busy}, 32'h1);
    check("single.in_ready", {31'd0, in_ready}, 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("single.y%0d", i), {28'd0, y}, 32'h4);
      check($sformatf("single.nodone%0d", i), {31'd0, done}, 32'h0);
    end
    tick();
    check("single.end_y", {28'd0, y}, 32'h0);
    check("single.done", {31'd0, done}, 32'h1);
    check("single.rdy", {31'd0, in_ready}, 32'h1);
    tick();
    check("single.done_pulse", {31'd0, done}, 32'h0);

    // Scan mode: sel=3, hold=0
`ifdef DEC_GAP_EN
    seq = '{8, 0, 1, 0, 2, 0, 4};
`else
    seq = '{8, 1, 2, 4};
`endif
    sel = 2'd3; hold = 4'd0; mode = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    foreach (seq[i]) begin
      if (i != 0) tick();
      check($sformatf("scan.y%0d", i), {28'd0, y}, 32'(seq[i]));
      check($sformatf("scan.busy%0d", i), {31'd0, busy}, 32'h1);
      check($sformatf("scan.nodone%0d", i), {31'd0, done}, 32'h0);
    end
    tick();
    check("scan.end_y", {28'd0, y}, 32'h0);
    check("scan.done", {31'd0, done}, 32'h1);
    tick();

    // en low stretch: sel=1, hold=1, 5 frozen cycles -> 7 cycles of 0010
    sel = 2'd1; hold = 4'd1; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("en.y_first", {28'd0, y}, 32'h2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      sel = 2'd0;
      tick();
      check($sformatf("en.hold_y%0d", i), {28'd0, y}, 32'h2);
      check($sformatf("en.rdy%0d", i), {31'd0, in_ready}, 32'h0);
      check($sformatf("en.nodone%0d", i), {31'd0, done}, 32'h0);
    end
    in_valid = 1'b0;
    en = 1'b1;
    tick();
    check("en.y_last", {28'd0, y}, 32'h2);
    tick();
    check("en.end_y", {28'd0, y}, 32'h0);
    check("en.done", {31'd0, done}, 32'h1);
    tick();
    check_idle("en.after");

    // Reset mid-scan: clears asynchronously, no done
    sel = 2'd0; hold = 4'd3; mode = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("arst.pre_y", {28'd0, y}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("arst");
    check("arst.done", {31'd0, done}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst.done_after", {31'd0, done}, 32'h0);
    check_idle("arst.after");

    // N=3, single, sel=7, hold=15 -> 16 cycles of 0x80, back-to-back request on done
    sel3 = 3'd7; hold3 = 4'd15; mode3 = 1'b0; in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) tick();
      check($sformatf("n3.y%0d", i), {24'd0, y3}, 32'h80);
    end
    tick();
    check("n3.end_y", {24'd0, y3}, 32'h0);
    check("n3.done", {31'd0, done3}, 32'h1);
    check("n3.rdy", {31'd0, in_ready3}, 32'h1);
    sel3 = 3'd0; hold3 = 4'd0; in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    check("n3.b2b_y", {24'd0, y3}, 32'h01);
    check("n3.b2b_busy", {31'd0, busy3}, 32'h1);
    check("n3.b2b_done_clr", {31'd0, done3}, 32'h0);
    tick();
    check("n3.b2b_end_y", {24'd0, y3}, 32'h0);
    check("n3.b2b_done", {31'd0, done3}, 32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
